psg_bus_master: RTL and testbench

- Host-side initiator for the PSG register bus: turns write requests (register, data) and read requests into BDIR/BC/DA bus cycles for a ym2149 instance.
- Sits between a CPU I/O port or music-player engine and the PSG.
- Buffers writes in a small FIFO and skips redundant address-latch phases.
- Reads are ordered behind all earlier writes.

---
 rtl/psg_bus_pkg.sv | 36 +++
 rtl/psg_bus_if.sv | 34 +++
 rtl/psg_wr_fifo.sv | 57 +++++
 rtl/psg_bus_master.sv | 210 +++++++++++++++++++++
 tb/tb_psg_bus_master.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psg_bus_pkg.sv
// Shared types and constants for the PSG bus master.
//   psg_state_e  : bus-cycle sequencer states
//   wr_entry_t   : one buffered register write {addr, data}
//   PSG_R_*      : register numbers with special meaning on the PSG
//   max3()       : elaboration-time helper for sizing the phase counter
package psg_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_SETUP,
        ST_ADDR_PULSE,
        ST_ADDR_GAP,
        ST_DATA_SETUP,
        ST_DATA_PULSE,
        ST_DATA_GAP,
        ST_READ_WIN,
        ST_READ_DONE
    } psg_state_e;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_entry_t;

    localparam logic [3:0] PSG_R_MIXER     = 4'd7;
    localparam logic [3:0] PSG_R_ENV_SHAPE = 4'd13;
    localparam logic [3:0] PSG_R_IOA       = 4'd14;
    localparam logic [3:0] PSG_R_IOB       = 4'd15;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/psg_bus_if.sv
// Host-side request/response signals plus the PSG pin bundle.
//   master : the bus master (drives WR_READY, RD_VALID/RD_DATA, BUSY,
//            FIFO_LEVEL, BDIR, BC, DA_OUT)
//   slave  : host and PSG side (drives WR_*, RD_REQ/RD_ADDR, DA_IN)
interface psg_bus_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             WR_VALID;
    logic             WR_READY;
    logic [3:0]       WR_ADDR;
    logic [7:0]       WR_DATA;
    logic             RD_REQ;
    logic [3:0]       RD_ADDR;
    logic             RD_VALID;
    logic [7:0]       RD_DATA;
    logic             BUSY;
    logic [LVL_W-1:0] FIFO_LEVEL;
    logic             BDIR;
    logic             BC;
    logic [7:0]       DA_OUT;
    logic [7:0]       DA_IN;

    modport master (
        input  WR_VALID, WR_ADDR, WR_DATA, RD_REQ, RD_ADDR, DA_IN,
        output WR_READY, RD_VALID, RD_DATA, BUSY, FIFO_LEVEL, BDIR, BC, DA_OUT
    );

    modport slave (
        output WR_VALID, WR_ADDR, WR_DATA, RD_REQ, RD_ADDR, DA_IN,
        input  WR_READY, RD_VALID, RD_DATA, BUSY, FIFO_LEVEL, BDIR, BC, DA_OUT
    );
endinterface

// File: rtl/psg_wr_fifo.sv
// Synchronous show-ahead FIFO for pending register writes.
//   CLK, RESET_N : clock, async active-low clear of pointers and level
//   push, wr_entry : enqueue (caller guarantees !full)
//   pop, rd_entry  : dequeue; rd_entry is the current head (caller guarantees !empty)
//   full, empty, level : occupancy status
module psg_wr_fifo
    import psg_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   push,
    input  wr_entry_t              wr_entry,
    input  logic                   pop,
    output wr_entry_t              rd_entry,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    wr_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;

    // NOTE: the storage array has no reset; only pointers and count need a
    // known state, and leaving the array unreset lets it map onto RAM.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_entry = mem[rd_ptr];
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;

endmodule

// File: rtl/psg_bus_master.sv
// PSG register-bus initiator. Buffers host writes, queues one read, and
// sequences BDIR/BC/DA bus cycles toward a ym2149. The address phase is
// skipped when the target register equals the last latched address.
//   CLK, RESET_N : clock, async active-low reset (aborts any bus cycle)
//   bus (master) : host request/response signals and PSG pins
module psg_bus_master
    import psg_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PULSE_LEN  = 2,
    parameter int GAP_LEN    = 1,
    parameter int RD_WAIT    = 2,
    parameter int ADDR_CACHE = 1
) (
    input  logic      CLK,
    input  logic      RESET_N,
    psg_bus_if.master bus
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(max3(PULSE_LEN, GAP_LEN, RD_WAIT)) + 1;

    // Counter reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_RELOAD   = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] WAIT_RELOAD  = CNT_W'(RD_WAIT - 1);

    psg_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             bdir_q, bc_q, rd_valid_q;
    logic [7:0]       da_out_q, rd_data_q;
    logic [3:0]       cur_addr;
    logic [7:0]       cur_data;
    logic             cur_is_rd;
    logic             cache_valid;
    logic [3:0]       cache_addr;
    logic             rd_pending;
    logic [3:0]       rd_addr_q;

    wr_entry_t        head;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [LVL_W-1:0] fifo_level;
    logic             wr_hit, rd_hit;

    // Writes take priority in IDLE, so a read never overtakes a buffered write.
    assign fifo_push = bus.WR_VALID && !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;

    assign wr_hit = (ADDR_CACHE != 0) && cache_valid && (head.addr == cache_addr);
    assign rd_hit = (ADDR_CACHE != 0) && cache_valid && (rd_addr_q == cache_addr);

    psg_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .push     (fifo_push),
        .wr_entry ('{addr: bus.WR_ADDR, data: bus.WR_DATA}),
        .pop      (fifo_pop),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // A second request while one is pending or in service is dropped.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_pending <= 1'b0;
            rd_addr_q  <= '0;
        end else if (state == ST_READ_DONE) begin
            rd_pending <= 1'b0;
        end else if (bus.RD_REQ && !rd_pending) begin
            rd_pending <= 1'b1;
            rd_addr_q  <= bus.RD_ADDR;
        end
    end

    // Outputs are loaded on state entry so BDIR/BC/DA_OUT come straight
    // from flops and change together with the state.
    // NOTE: every assignment in this clocked block is non-blocking so all
    // state and outputs update from the same pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bdir_q      <= 1'b0;
            bc_q        <= 1'b0;
            da_out_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            cur_addr    <= '0;
            cur_data    <= '0;
            cur_is_rd   <= 1'b0;
            cache_valid <= 1'b0;
            cache_addr  <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_addr  <= head.addr;
                        cur_data  <= head.data;
                        cur_is_rd <= 1'b0;
                        cnt       <= '0;
                        if (wr_hit) begin
                            state    <= ST_DATA_SETUP;
                            bc_q     <= 1'b0;
                            da_out_q <= head.data;
                        end else begin
                            state    <= ST_ADDR_SETUP;
                            bc_q     <= 1'b1;
                            da_out_q <= {4'b0000, head.addr};
                        end
                    end else if (rd_pending) begin
                        cur_addr  <= rd_addr_q;
                        cur_is_rd <= 1'b1;
                        bc_q      <= 1'b1;
                        if (rd_hit) begin
                            state <= ST_READ_WIN;
                            cnt   <= WAIT_RELOAD;
                        end else begin
                            state    <= ST_ADDR_SETUP;
                            cnt      <= '0;
                            da_out_q <= {4'b0000, rd_addr_q};
                        end
                    end
                end
                ST_ADDR_SETUP: begin
                    state  <= ST_ADDR_PULSE;
                    cnt    <= PULSE_RELOAD;
                    bdir_q <= 1'b1;
                end
                ST_ADDR_PULSE: begin
                    if (cnt == '0) begin
                        state       <= ST_ADDR_GAP;
                        cnt         <= GAP_RELOAD;
                        bdir_q      <= 1'b0;
                        cache_valid <= 1'b1;
                        cache_addr  <= cur_addr;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ADDR_GAP: begin
                    if (cnt == '0) begin
                        if (cur_is_rd) begin
                            state <= ST_READ_WIN;
                            cnt   <= WAIT_RELOAD;
                        end else begin
                            state    <= ST_DATA_SETUP;
                            cnt      <= '0;
                            bc_q     <= 1'b0;
                            da_out_q <= cur_data;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DATA_SETUP: begin
                    state  <= ST_DATA_PULSE;
                    cnt    <= PULSE_RELOAD;
                    bdir_q <= 1'b1;
                end
                ST_DATA_PULSE: begin
                    if (cnt == '0) begin
                        state  <= ST_DATA_GAP;
                        cnt    <= GAP_RELOAD;
                        bdir_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DATA_GAP: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_READ_WIN: begin
                    if (cnt == '0) begin
                        state      <= ST_READ_DONE;
                        cnt        <= '0;
                        bc_q       <= 1'b0;
                        rd_data_q  <= bus.DA_IN;
                        rd_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_READ_DONE: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.WR_READY   = !fifo_full;
    assign bus.FIFO_LEVEL = fifo_level;
    assign bus.BUSY       = (state != ST_IDLE) || !fifo_empty || rd_pending;
    assign bus.BDIR       = bdir_q;
    assign bus.BC         = bc_q;
    assign bus.DA_OUT     = da_out_q;
    assign bus.RD_VALID   = rd_valid_q;
    assign bus.RD_DATA    = rd_data_q;

endmodule

// File: tb/tb_psg_bus_master.sv
// Directed bench for psg_bus_master with a small ym2149 register model
// that latches address/data on the sampled BDIR rising edge.
module tb_psg_bus_master;
    import psg_bus_pkg::*;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    psg_bus_if #(.FIFO_DEPTH(4)) bus ();

    psg_bus_master #(
        .FIFO_DEPTH(4), .PULSE_LEN(2), .GAP_LEN(1), .RD_WAIT(2), .ADDR_CACHE(1)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- PSG model ----------------
    logic [7:0]  psg_regs [16];
    logic [3:0]  psg_latch;
    logic        psg_bdir_q;
    logic [11:0] wr_log [$];

    function automatic logic [7:0] psg_mask(input logic [3:0] a);
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13: return 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10: return 8'h1F;
            default:                 return 8'hFF;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) psg_regs[i] <= 8'h00;
            psg_latch  <= 4'd0;
            psg_bdir_q <= 1'b0;
        end else begin
            if (bus.BDIR && !psg_bdir_q) begin
                if (bus.BC) begin
                    psg_latch <= bus.DA_OUT[3:0];
                end else begin
                    psg_regs[psg_latch] <= bus.DA_OUT & psg_mask(psg_latch);
                    wr_log.push_back({psg_latch, bus.DA_OUT});
                end
            end
            psg_bdir_q <= bus.BDIR;
        end
    end

    assign bus.DA_IN = (bus.BC && !bus.BDIR) ? psg_regs[psg_latch] : 8'hFF;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n        = 1'b0;
        bus.WR_VALID = 1'b0;
        bus.WR_ADDR  = 4'd0;
        bus.WR_DATA  = 8'd0;
        bus.RD_REQ   = 1'b0;
        bus.RD_ADDR  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.BDIR !== 1'b0)       begin bad++; $display("FAIL reset_bdir: got %b want 0", bus.BDIR); end
        total++; if (bus.BC !== 1'b0)         begin bad++; $display("FAIL reset_bc: got %b want 0", bus.BC); end
        total++; if (bus.DA_OUT !== 8'h00)    begin bad++; $display("FAIL reset_da_out: got %h want 00", bus.DA_OUT); end
        total++; if (bus.RD_VALID !== 1'b0)   begin bad++; $display("FAIL reset_rd_valid: got %b want 0", bus.RD_VALID); end
        total++; if (bus.RD_DATA !== 8'h00)   begin bad++; $display("FAIL reset_rd_data: got %h want 00", bus.RD_DATA); end
        total++; if (bus.FIFO_LEVEL !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", bus.FIFO_LEVEL); end
        total++; if (bus.WR_READY !== 1'b1)   begin bad++; $display("FAIL reset_wr_ready: got %b want 1", bus.WR_READY); end
        total++; if (bus.BUSY !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        logic [9:0] exp_tr [9];
        logic [9:0] obs;
        exp_tr = '{{2'b01, 8'h07}, {2'b11, 8'h07}, {2'b11, 8'h07}, {2'b01, 8'h07},
                   {2'b00, 8'h38}, {2'b10, 8'h38}, {2'b10, 8'h38}, {2'b00, 8'h38},
                   {2'b00, 8'h38}};
        bus.WR_VALID = 1'b1;
        bus.WR_ADDR  = PSG_R_MIXER;
        bus.WR_DATA  = 8'h38;
        tick();
        bus.WR_VALID = 1'b0;
        total++; if (bus.FIFO_LEVEL !== 3'd1) begin bad++; $display("FAIL single_level: got %0d want 1", bus.FIFO_LEVEL); end
        for (int i = 0; i < 9; i++) begin
            tick();
            obs = {bus.BDIR, bus.BC, bus.DA_OUT};
            total++;
            if (obs !== exp_tr[i]) begin
                bad++;
                $display("FAIL single_trace[%0d]: got bdir/bc/da %h want %h", i, obs, exp_tr[i]);
            end
        end
        total++; if (bus.BUSY !== 1'b0)       begin bad++; $display("FAIL single_idle: busy got %b want 0", bus.BUSY); end
        tick();
        total++; if (psg_regs[7] !== 8'h38)   begin bad++; $display("FAIL single_psg_r7: got %h want 38", psg_regs[7]); end
    endtask

    task automatic test_addr_cache();
        logic [9:0] exp_tr [14];
        logic [9:0] obs;
        exp_tr = '{{2'b01, 8'h08}, {2'b11, 8'h08}, {2'b11, 8'h08}, {2'b01, 8'h08},
                   {2'b00, 8'h0F}, {2'b10, 8'h0F}, {2'b10, 8'h0F}, {2'b00, 8'h0F},
                   {2'b00, 8'h0F},
                   {2'b00, 8'h1F}, {2'b10, 8'h1F}, {2'b10, 8'h1F}, {2'b00, 8'h1F},
                   {2'b00, 8'h1F}};
        bus.WR_VALID = 1'b1;
        bus.WR_ADDR  = 4'd8;
        bus.WR_DATA  = 8'h0F;
        tick();
        bus.WR_DATA  = 8'h1F;
        tick();
        bus.WR_VALID = 1'b0;
        total++; if (bus.FIFO_LEVEL !== 3'd1) begin bad++; $display("FAIL cache_level: got %0d want 1", bus.FIFO_LEVEL); end
        for (int i = 0; i < 14; i++) begin
            if (i != 0) tick();
            obs = {bus.BDIR, bus.BC, bus.DA_OUT};
            total++;
            if (obs !== exp_tr[i]) begin
                bad++;
                $display("FAIL cache_trace[%0d]: got bdir/bc/da %h want %h", i, obs, exp_tr[i]);
            end
        end
        total++; if (bus.BUSY !== 1'b0)       begin bad++; $display("FAIL cache_idle: busy got %b want 0", bus.BUSY); end
        tick();
        total++; if (psg_regs[8] !== 8'h1F)   begin bad++; $display("FAIL cache_psg_r8: got %h want 1F", psg_regs[8]); end
    endtask

    task automatic test_fifo_full();
        logic [3:0]  ea [5];
        logic [7:0]  ed [5];
        int          base, stall, rd_seen, n, prev_lvl, rise;
        ea = '{4'd0, 4'd2, 4'd4, 4'd9, 4'd10};
        ed = '{8'h11, 8'h22, 8'h44, 8'h15, 8'h1A};
        base = wr_log.size();
        // A read of register 5 keeps the sequencer busy so pushes accumulate.
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = 4'd5;
        tick();
        bus.RD_REQ   = 1'b0;
        bus.WR_VALID = 1'b1;
        bus.WR_ADDR  = ea[0];
        bus.WR_DATA  = ed[0];
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (bus.FIFO_LEVEL !== 3'(i + 1)) begin
                bad++; $display("FAIL full_level[%0d]: got %0d want %0d", i, bus.FIFO_LEVEL, i + 1);
            end
            total++;
            if (bus.WR_READY !== (i != 3)) begin
                bad++; $display("FAIL full_ready[%0d]: got %b want %b", i, bus.WR_READY, (i != 3));
            end
            bus.WR_ADDR = ea[i + 1];
            bus.WR_DATA = ed[i + 1];
        end
        stall   = 0;
        rd_seen = 0;
        while (!bus.WR_READY && stall < 30) begin
            tick();
            stall++;
            if (bus.RD_VALID) rd_seen++;
        end
        total++; if (stall !== 5)             begin bad++; $display("FAIL full_stall: got %0d cycles want 5", stall); end
        total++; if (bus.FIFO_LEVEL !== 3'd3) begin bad++; $display("FAIL full_after_pop: got %0d want 3", bus.FIFO_LEVEL); end
        total++; if (rd_seen !== 1)           begin bad++; $display("FAIL full_rd_pulses: got %0d want 1", rd_seen); end
        total++; if (bus.RD_DATA !== 8'h00)   begin bad++; $display("FAIL full_rd_data: got %h want 00", bus.RD_DATA); end
        tick();
        bus.WR_VALID = 1'b0;
        total++; if (bus.FIFO_LEVEL !== 3'd4) begin bad++; $display("FAIL full_fifth_push: got %0d want 4", bus.FIFO_LEVEL); end
        n        = 0;
        rise     = 0;
        prev_lvl = int'(bus.FIFO_LEVEL);
        while (bus.BUSY && n < 100) begin
            tick();
            n++;
            if (int'(bus.FIFO_LEVEL) > prev_lvl) rise++;
            prev_lvl = int'(bus.FIFO_LEVEL);
        end
        total++; if (n >= 100)                begin bad++; $display("FAIL full_drain_timeout: got %0d cycles want <100", n); end
        total++; if (rise !== 0)              begin bad++; $display("FAIL full_level_rose: got %0d increases want 0", rise); end
        total++; if (bus.FIFO_LEVEL !== 3'd0) begin bad++; $display("FAIL full_drained: got %0d want 0", bus.FIFO_LEVEL); end
        tick();
        total++;
        if (wr_log.size() !== base + 5) begin
            bad++; $display("FAIL full_log_size: got %0d want %0d", wr_log.size() - base, 5);
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (wr_log[base + i] !== {ea[i], ed[i]}) begin
                    bad++; $display("FAIL full_order[%0d]: got %h want %h", i, wr_log[base + i], {ea[i], ed[i]});
                end
            end
        end
    endtask

    // Write one register, request a read of it one cycle later, and expect
    // RD_VALID exactly 11 cycles after the request edge (8-cycle write miss,
    // one IDLE cycle, read hit: 2 window cycles then the done cycle).
    task automatic wr_then_rd(input string nm, input logic [3:0] a,
                              input logic [7:0] d, input logic [7:0] exp_rd);
        int n;
        bus.WR_VALID = 1'b1;
        bus.WR_ADDR  = a;
        bus.WR_DATA  = d;
        tick();
        bus.WR_VALID = 1'b0;
        bus.RD_REQ   = 1'b1;
        bus.RD_ADDR  = a;
        tick();
        bus.RD_REQ   = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.RD_VALID && n < 40);
        total++; if (n !== 11)                begin bad++; $display("FAIL %s_latency: got %0d want 11", nm, n); end
        total++; if (bus.RD_DATA !== exp_rd)  begin bad++; $display("FAIL %s_data: got %h want %h", nm, bus.RD_DATA, exp_rd); end
        tick();
        total++; if (bus.RD_VALID !== 1'b0)   begin bad++; $display("FAIL %s_pulse: got %b want 0", nm, bus.RD_VALID); end
        total++; if (bus.RD_DATA !== exp_rd)  begin bad++; $display("FAIL %s_hold: got %h want %h", nm, bus.RD_DATA, exp_rd); end
        total++; if (bus.BUSY !== 1'b0)       begin bad++; $display("FAIL %s_idle: busy got %b want 0", nm, bus.BUSY); end
    endtask

    task automatic test_read_after_write();
        wr_then_rd("rd_after_wr", 4'd0, 8'hA5, 8'hA5);
    endtask

    task automatic test_masked_read();
        wr_then_rd("masked_rd", 4'd1, 8'hFF, 8'h0F);
    endtask

    task automatic test_reset_abort();
        int n, bc_cyc, rises;
        logic prev_bdir;
        bus.WR_VALID = 1'b1;
        bus.WR_ADDR  = 4'd3;
        bus.WR_DATA  = 8'h55;
        tick();
        bus.WR_DATA  = 8'h77;
        tick();
        bus.WR_VALID = 1'b0;
        n = 0;
        while (!(bus.BDIR && !bus.BC) && n < 20) begin
            tick();
            n++;
        end
        total++; if (n >= 20)                 begin bad++; $display("FAIL abort_wait: got %0d cycles want <20", n); end
        total++; if (bus.FIFO_LEVEL !== 3'd1) begin bad++; $display("FAIL abort_level_pre: got %0d want 1", bus.FIFO_LEVEL); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (bus.BDIR !== 1'b0)       begin bad++; $display("FAIL abort_bdir: got %b want 0", bus.BDIR); end
        total++; if (bus.FIFO_LEVEL !== 3'd0) begin bad++; $display("FAIL abort_level: got %0d want 0", bus.FIFO_LEVEL); end
        total++; if (bus.BUSY !== 1'b0)       begin bad++; $display("FAIL abort_busy: got %b want 0", bus.BUSY); end
        #2;
        rst_n = 1'b1;
        tick();
        bus.WR_VALID = 1'b1;
        bus.WR_ADDR  = 4'd3;
        bus.WR_DATA  = 8'h66;
        tick();
        bus.WR_VALID = 1'b0;
        n         = 0;
        bc_cyc    = 0;
        rises     = 0;
        prev_bdir = 1'b0;
        while (bus.BUSY && n < 30) begin
            tick();
            n++;
            if (bus.BC) bc_cyc++;
            if (bus.BDIR && !prev_bdir) rises++;
            prev_bdir = bus.BDIR;
        end
        total++; if (n !== 9)                 begin bad++; $display("FAIL abort_rewrite_len: got %0d want 9", n); end
        total++; if (bc_cyc !== 4)            begin bad++; $display("FAIL abort_addr_phase: got %0d bc cycles want 4", bc_cyc); end
        total++; if (rises !== 2)             begin bad++; $display("FAIL abort_pulses: got %0d want 2", rises); end
        tick();
        total++; if (psg_regs[3] !== 8'h06)   begin bad++; $display("FAIL abort_psg_r3: got %h want 06", psg_regs[3]); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_addr_cache();
        test_fifo_full();
        test_read_after_write();
        test_masked_read();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
